// File: rtl/aes_sbox_sequencer_pkg.sv
// Shared types and sizing helpers for the time-multiplexed AES SubWord sequencer.
package aes_sbox_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int REQ_COUNT = 2;
  localparam int WORD_W    = 32;

  // Number of substitution steps needed to cover all four bytes of a word.
  function automatic int sbox_steps(input int num_sbox);
    return 4 / num_sbox;
  endfunction

endpackage

// File: rtl/aes_sbox_sequencer_if.sv
// Request/response bundle between the requesters, the consumer and the sequencer.
interface aes_sbox_sequencer_if;
  import aes_sbox_seq_pkg::*;

  logic [REQ_COUNT-1:0]        req_valid_i;
  logic [REQ_COUNT*WORD_W-1:0] req_word_i;
  logic [REQ_COUNT-1:0]        req_ready_o;
  logic                        resp_valid_o;
  logic                        resp_ready_i;
  logic [WORD_W-1:0]           resp_word_o;
  logic                        resp_id_o;

  modport slave (
    input  req_valid_i, req_word_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_word_o, resp_id_o
  );

  modport master (
    output req_valid_i, req_word_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_word_o, resp_id_o
  );

endinterface

// File: rtl/aes_sbox_rr_arb.sv
// Two-way round-robin arbiter; the pointer flips away from whoever was just served.
module aes_sbox_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr_q;
  logic take;

  always_comb begin
    gnt_id = 1'b0;
    unique case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
    grant = (en && (req != 2'b00)) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    take  = |(grant & req);
  end

  always_ff @(posedge clk) begin
    if (reset)     ptr_q <= 1'b0;
    else if (take) ptr_q <= ~gnt_id;
  end

endmodule

// File: rtl/riscv_crypto_aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module riscv_crypto_aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = a;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(x);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sbox_sequencer.sv
// Shares NUM_SBOX forward S-boxes between two requesters, substituting one word
// NUM_SBOX bytes per cycle and returning the result on a tagged response channel.
module aes_sbox_sequencer
  import aes_sbox_seq_pkg::*;
#(
  parameter int NUM_SBOX = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  aes_sbox_sequencer_if.slave  bus
);

  localparam int K = sbox_steps(NUM_SBOX);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   work_q, work_d;
  logic                id_q, id_d;

  logic [1:0]          grant;
  logic                gnt_id;
  logic                arb_en;
  logic                accept;
  logic [1:0]          base;
  logic [NUM_SBOX*8-1:0] sb_in;
  logic [NUM_SBOX*8-1:0] sb_out;

  // First byte index touched by the current step.
  if (NUM_SBOX == 1) begin : g_base1
    assign base = cnt_q;
  end else if (NUM_SBOX == 2) begin : g_base2
    assign base = {cnt_q[0], 1'b0};
  end else if (NUM_SBOX == 4) begin : g_base4
    assign base = 2'b00;
  end else begin : g_bad
    $error("aes_sbox_sequencer: NUM_SBOX must be 1, 2 or 4");
    assign base = 2'b00;
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    logic [1:0] idx;
    assign idx = base + 2'(j);
    assign sb_in[j*8 +: 8] = work_q[{idx, 3'b000} +: 8];
    riscv_crypto_aes_sbox u_sbox (
      .x (sb_in[j*8 +: 8]),
      .y (sb_out[j*8 +: 8])
    );
  end

  assign arb_en = (state_q == IDLE) && !flush_i && !reset;

  aes_sbox_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid_i),
    .en     (arb_en),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready_o = grant;
  assign accept          = |(grant & bus.req_valid_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    id_d    = id_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            work_d  = gnt_id ? bus.req_word_i[WORD_W +: WORD_W] : bus.req_word_i[0 +: WORD_W];
            id_d    = gnt_id;
            cnt_d   = 2'd0;
            state_d = SUB;
          end
        end
        SUB: begin
          for (int j = 0; j < NUM_SBOX; j++) begin
            work_d[{base + 2'(j), 3'b000} +: 8] = sb_out[j*8 +: 8];
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(K - 1)) state_d = DONE;
        end
        DONE: begin
          if (bus.resp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      id_q    <= id_d;
    end
  end

  assign bus.resp_valid_o = (state_q == DONE);
  assign bus.resp_word_o  = work_q;
  assign bus.resp_id_o    = id_q;

endmodule

// File: tb/tb_aes_sbox_sequencer.sv
// Randomised and directed bench for aes_sbox_sequencer against a transaction-level model.
module tb_aes_sbox_sequencer;
  import aes_sbox_seq_pkg::*;

  localparam int K1 = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_word = '0;

  always #5 clk = ~clk;

  aes_sbox_sequencer_if if1();
  aes_sbox_sequencer_if if2();
  aes_sbox_sequencer_if if4();

  assign if1.req_valid_i  = req_valid;
  assign if1.req_word_i   = req_word;
  assign if1.resp_ready_i = resp_ready;
  assign if2.req_valid_i  = req_valid;
  assign if2.req_word_i   = req_word;
  assign if2.resp_ready_i = resp_ready;
  assign if4.req_valid_i  = req_valid;
  assign if4.req_word_i   = req_word;
  assign if4.resp_ready_i = resp_ready;

  aes_sbox_sequencer #(.NUM_SBOX(1)) dut1 (.clk(clk), .reset(reset), .flush_i(flush), .bus(if1.slave));
  aes_sbox_sequencer #(.NUM_SBOX(2)) dut2 (.clk(clk), .reset(reset), .flush_i(flush), .bus(if2.slave));
  aes_sbox_sequencer #(.NUM_SBOX(4)) dut4 (.clk(clk), .reset(reset), .flush_i(flush), .bus(if4.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference S-box built from the generator-3 walk over GF(2^8).
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d;
    d = {v, v} << s;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] xv;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      xv = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = xv ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_t[w[8*b +: 8]];
    return r;
  endfunction

  // Transaction model: at most one word in flight, due a fixed number of edges after accept.
  bit          m_busy = 1'b0;
  int          m_rdy_cyc = 0;
  logic [31:0] m_word = '0;
  bit          m_id = 1'b0;
  bit          m_fav = 1'b0;
  logic [32:0] got_q [$];
  int          last_acc_edge = 0;
  int          last_rise = 0;
  bit          prev_valid = 1'b0;

  bit          seen2 = 1'b0, seen4 = 1'b0;
  int          rise2 = 0, rise4 = 0;
  logic [31:0] word2 = '0, word4 = '0;

  always @(negedge clk) begin
    if (if2.resp_valid_o === 1'b1 && !seen2) begin
      seen2 = 1'b1; rise2 = cyc; word2 = if2.resp_word_o;
    end
    if (if4.resp_valid_o === 1'b1 && !seen4) begin
      seen4 = 1'b1; rise4 = cyc; word4 = if4.resp_word_o;
    end
  end

  task automatic step(input logic rst_i, input logic fl_i, input logic [1:0] v_i,
                      input logic [63:0] w_i, input logic rr_i, output logic [1:0] acc);
    bit         exp_v;
    logic [1:0] exp_rdy;
    bit         g;
    exp_v = m_busy && (cyc >= m_rdy_cyc);
    expect_eq("resp_valid", 32'(if1.resp_valid_o), 32'(exp_v));
    if (exp_v) begin
      expect_eq("resp_word", if1.resp_word_o, m_word);
      expect_eq("resp_id", 32'(if1.resp_id_o), 32'(m_id));
    end
    if (if1.resp_valid_o === 1'b1 && !prev_valid) last_rise = cyc;
    prev_valid = (if1.resp_valid_o === 1'b1);
    reset = rst_i; flush = fl_i; req_valid = v_i; req_word = w_i; resp_ready = rr_i;
    #1;
    exp_rdy = 2'b00;
    g = (v_i == 2'b11) ? m_fav : v_i[1];
    if (!rst_i && !fl_i && !m_busy && v_i != 2'b00) exp_rdy[g] = 1'b1;
    expect_eq("req_ready", 32'(if1.req_ready_o), 32'(exp_rdy));
    acc = exp_rdy & v_i;
    if (!rst_i && exp_v && rr_i) got_q.push_back({m_id, m_word});
    if (rst_i) begin
      m_busy = 1'b0; m_fav = 1'b0;
    end else if (fl_i || (exp_v && rr_i)) begin
      m_busy = 1'b0;
    end else if (acc != 2'b00) begin
      m_busy = 1'b1; m_id = g;
      m_word = subword(g ? w_i[63:32] : w_i[31:0]);
      m_rdy_cyc = cyc + 1 + K1;
      m_fav = ~g;
      last_acc_edge = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic [1:0] acc;
    repeat (n) step(1'b0, 1'b0, 2'b00, 64'h0, rr, acc);
  endtask

  task automatic send(input bit id, input logic [31:0] w, input logic rr);
    logic [1:0] acc;
    int n = 0;
    do begin
      step(1'b0, 1'b0, id ? 2'b10 : 2'b01, id ? {w, 32'h0} : {32'h0, w}, rr, acc);
      n++;
    end while (acc == 2'b00 && n < 40);
    if (acc == 2'b00) expect_eq("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_pair(input logic [31:0] w0, input logic [31:0] w1);
    logic [1:0] acc;
    logic [1:0] pend = 2'b11;
    int n = 0;
    while (pend != 2'b00 && n < 60) begin
      step(1'b0, 1'b0, pend, {w1, w0}, 1'b1, acc);
      pend = pend & ~acc;
      n++;
    end
    if (pend != 2'b00) expect_eq("pair_timeout", 32'(pend), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  acc;
    logic [1:0]  pend;
    logic [63:0] pw;
    int          a;
    build_sbox();
    repeat (2) @(negedge clk);

    // Reset state, with both requesters valid so ready must still stay low.
    step(1'b1, 1'b0, 2'b11, 64'h1, 1'b1, acc);
    step(1'b1, 1'b0, 2'b11, 64'h1, 1'b1, acc);
    expect_eq("rst_word", if1.resp_word_o, 32'h0);
    expect_eq("rst_id", 32'(if1.resp_id_o), 32'd0);

    // Single request, plus latency of all three build widths.
    got_q.delete();
    send(1'b0, 32'h00010253, 1'b1);
    a = last_acc_edge;
    idle(8, 1'b1);
    expect_eq("single_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      expect_eq("single_word", got_q[0][31:0], 32'h637c77ed);
      expect_eq("single_id", 32'(got_q[0][32]), 32'd0);
    end
    expect_eq("single_lat", 32'(last_rise - a + 1), 32'd5);
    expect_eq("n2_lat", 32'(rise2 - a + 1), 32'd3);
    expect_eq("n2_word", word2, 32'h637c77ed);
    expect_eq("n4_lat", 32'(rise4 - a + 1), 32'd2);
    expect_eq("n4_word", word4, 32'h637c77ed);

    // Both requesters valid right after reset: alternation 0,1,0,1.
    step(1'b1, 1'b0, 2'b00, 64'h0, 1'b1, acc);
    got_q.delete();
    send_pair(32'hffffffff, 32'h00000000);
    idle(8, 1'b1);
    send_pair(32'h12345678, 32'hdeadbeef);
    idle(8, 1'b1);
    expect_eq("pair_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      expect_eq("pair0_word", got_q[0][31:0], 32'h16161616);
      expect_eq("pair0_id", 32'(got_q[0][32]), 32'd0);
      expect_eq("pair1_word", got_q[1][31:0], 32'h63636363);
      expect_eq("pair1_id", 32'(got_q[1][32]), 32'd1);
      expect_eq("pair2_id", 32'(got_q[2][32]), 32'd0);
      expect_eq("pair3_id", 32'(got_q[3][32]), 32'd1);
      expect_eq("pair3_word", got_q[3][31:0], subword(32'hdeadbeef));
    end

    // Backpressure: response held for many cycles while both requesters wait.
    got_q.delete();
    send(1'b1, 32'hcafef00d, 1'b0);
    repeat (K1 + 12) step(1'b0, 1'b0, 2'b11, {$urandom, $urandom}, 1'b0, acc);
    idle(4, 1'b1);
    expect_eq("bp_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) expect_eq("bp_word", got_q[0][31:0], subword(32'hcafef00d));

    // Flush in the second SUB cycle, then an immediate new request.
    got_q.delete();
    send(1'b0, 32'h11223344, 1'b1);
    step(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, acc);
    step(1'b0, 1'b1, 2'b01, 64'h0, 1'b1, acc);
    send(1'b0, 32'h53535353, 1'b1);
    idle(8, 1'b1);
    expect_eq("flush_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) expect_eq("flush_next_word", got_q[0][31:0], 32'hedededed);

    // Reset while DONE is stalled; the pointer must favour requester 0 again.
    got_q.delete();
    send(1'b0, 32'h0badf00d, 1'b0);
    repeat (K1 + 2) step(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, acc);
    step(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, acc);
    send_pair(32'h01020304, 32'h05060708);
    idle(8, 1'b1);
    expect_eq("rstdone_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() > 0) expect_eq("rstdone_first_id", 32'(got_q[0][32]), 32'd0);

    // Random traffic with occasional flush and reset.
    pend = 2'b00;
    pw = '0;
    for (int i = 0; i < 1500; i++) begin
      logic rr, fl, rs;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom % 3 == 0)) begin
          pend[r] = 1'b1;
          pw[32*r +: 32] = $urandom;
        end
      end
      rr = ($urandom % 4) != 0;
      fl = ($urandom % 40) == 0;
      rs = ($urandom % 300) == 0;
      step(rs, fl, pend, pw, rr, acc);
      pend = pend & ~acc;
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/aes_sbox_sequencer.md
Name: aes_sbox_sequencer

Overview:
- Shares a small number of forward AES S-box lookup instances between two requesters: requester 0 is the aes32 instruction path and requester 1 is key-expansion/microcode.
- Each request carries one 32-bit word; the block returns SubWord of it, with every byte substituted independently.
- The block time-multiplexes NUM_SBOX S-box copies over the 4 bytes, arbitrates round-robin between requesters, and returns results over a single valid/ready response channel tagged with requester id.
- It sits inside the crypto execute unit, beside the AES mix/xor datapath.

Parameters:
- NUM_SBOX, 1, number of S-box instances. Legal values are 1, 2 and 4; any other value is an elaboration error. Bytes per step = NUM_SBOX; steps per word K = 4/NUM_SBOX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  abort any in-flight request (pipeline flush).
- req_valid_i  in  2  per-requester request valid (bit i = requester i).
- req_word_i  in  64  packed words: [31:0] requester 0, [63:32] requester 1.
- req_ready_o  out  2  per-requester accept strobe.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer accepts the result.
- resp_word_o  out  32  SubWord result.
- resp_id_o  out  1  requester that issued the returned word.

Behaviour:
- Reset, active on a clk edge with reset=1:
  - state=IDLE, rr pointer favours requester 0, step counter=0.
  - resp_valid_o=0, resp_word_o=0, resp_id_o=0.
  - req_ready_o=0 while reset is high.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - grant is combinational from req_valid_i and the rr pointer. If only one requester is valid, it is granted. If both are valid, the pointer-favoured requester is granted.
  - req_ready_o[g]=1 only for the granted requester, and only in IDLE. A transfer happens when valid&ready.
  - ready may depend on valid; requesters must not make valid depend on ready.
  - On accept:
    - latch the word into the working register and latch the id;
    - counter=0, go to SUB;
    - the rr pointer moves to favour the other requester.
- SUB:
  - each cycle, bytes [counter*NUM_SBOX +: NUM_SBOX] of the working register are passed through the S-boxes and written back in place. Byte i of the output is SBOX(byte i of the input), with byte 0 = bits [7:0].
  - counter increments each cycle. On the step where counter==K-1, go to DONE.
- DONE:
  - resp_valid_o=1; resp_word_o and resp_id_o are held stable until resp_ready_i=1.
  - on the handshake, go to IDLE; resp_valid_o drops the next cycle.
  - no new request is accepted in the same cycle as a response handshake.
- Latency: accept at edge T; resp_valid_o high after edge T+K. That gives K+1 cycles accept-to-valid: 5 cycles for NUM_SBOX=1, 3 for 2, 2 for 4.
- Throughput: one word per K+2 cycles when resp_ready_i is held high.
- flush_i:
  - has priority over everything except reset. Next state is IDLE, counter=0, resp_valid_o=0 the next cycle.
  - req_ready_o is forced 0 in any cycle flush_i=1, so nothing is accepted.
  - the rr pointer is unchanged.
  - a response whose resp_ready_i coincides with flush_i is treated as consumed.
- Reset mid-operation aborts identically to flush, plus the pointer reset.
- Backpressure: resp_ready_i low holds DONE indefinitely. req_ready_o stays 0 throughout, and there is no loss or overwrite.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1...

Decomposition:
- Package aes_sbox_seq_pkg holds:
  - the state enum (IDLE, SUB, DONE);
  - REQ_COUNT=2 and WORD_W=32;
  - a localparam function computing K from NUM_SBOX.
- Sub-module aes_sbox_rr_arb (2-way round-robin grant plus pointer register) is natural and reusable.
- The S-box itself is the existing riscv_crypto_aes_sbox, instantiated NUM_SBOX times in a generate loop.

Test Plan:
- Single request, NUM_SBOX=1: requester 0 sends 0x00010253, resp_ready held 1 → resp_word_o=0x637c77ed and resp_id_o=0, valid exactly 5 cycles after accept.
- Both requesters valid from reset: 0 sends 0xffffffff, 1 sends 0x00000000 → responses are 0x16161616 (id 0) first, then 0x63636363 (id 1). A second back-to-back pair is granted 0 then 1, confirming alternation.
- Backpressure: hold resp_ready_i=0 for 10 cycles in DONE → resp_word_o and resp_id_o stay stable, req_ready_o stays 00, and the result is delivered once on release.
- Flush in SUB (cycle 2 after accept) → resp_valid_o never asserts for that word, the block is back in IDLE next cycle, and the next request 0x53535353 returns 0xedededed.
- NUM_SBOX=2 and 4 builds with the same vector 0x00010253 → same result, with valid at 3 and 2 cycles after accept respectively.
- Reset asserted while in DONE → resp_valid_o=0 the cycle after, and the rr pointer favours 0 again.
